// File: rtl/apb2axi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb2axi_pkg
// Brief    : Shared types and constants for the APB-to-AXI read data buffer.
// Revision : 1.0 - initial release
// ============================================================================
package apb2axi_pkg;

  typedef enum logic [1:0] {
    RB_FREE    = 2'd0,
    RB_FILLING = 2'd1,
    RB_DONE    = 2'd2
  } rbuf_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'd0;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'd1;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'd2;
  localparam logic [1:0] AXI_RESP_DECERR = 2'd3;

  // Completion tag field is fixed here; the buffer's TAG_W must not exceed it.
  localparam int CPL_TAG_W    = 4;
  localparam int COMPLETION_W = CPL_TAG_W + 3;

  typedef struct packed {
    logic [CPL_TAG_W-1:0] tag;
    logic [1:0]           resp;
    logic                 len_err;
  } completion_t;

  // Encodings are ordered by severity, so the worst response is the numeric max.
  function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb2axi_rbuf_ram.sv
`default_nettype none
// ============================================================================
// Module   : apb2axi_rbuf_ram
// Brief    : Simple dual-port beat store, one write port and one registered
//            read port (read-before-write). Optional per-byte even parity under
//            APB2AXI_RBUF_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module apb2axi_rbuf_ram #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
`ifdef APB2AXI_RBUF_PARITY_EN
  input  logic              par_inject,
  output logic [DATA_W/8-1:0] rd_par,
`endif
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
    rd_data <= r_mem[rd_addr];
  end

`ifdef APB2AXI_RBUF_PARITY_EN
  localparam int NBYTES = DATA_W / 8;

  logic [NBYTES-1:0] r_par_mem [DEPTH];
  logic [NBYTES-1:0] w_wr_par;

  for (genvar b = 0; b < NBYTES; b++) begin : g_par_gen
    if (b == 0) begin : g_inject
      assign w_wr_par[b] = (^wr_data[8*b +: 8]) ^ par_inject;
    end else begin : g_plain
      assign w_wr_par[b] = ^wr_data[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) r_par_mem[wr_addr] <= w_wr_par;
    rd_par <= r_par_mem[rd_addr];
  end
`endif

endmodule
`default_nettype wire

// File: rtl/apb2axi_rdata_buffer.sv
`default_nettype none
// ============================================================================
// Module   : apb2axi_rdata_buffer
// Brief    : Per-tag AXI R-channel beat buffer with burst completions and APB
//            word readback. Parity option: APB2AXI_RBUF_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module apb2axi_rdata_buffer
  import apb2axi_pkg::*;
#(
  parameter int AXI_ID_W   = 4,
  parameter int AXI_DATA_W = 64,
  parameter int APB_DATA_W = 32,
  parameter int TAG_W      = 4,
  parameter int MAX_BEATS  = 16,
  localparam int WORDS     = AXI_DATA_W / APB_DATA_W,
  localparam int RB_WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  alloc_valid,
  output logic                  alloc_ready,
  input  logic [TAG_W-1:0]      alloc_tag,
  input  logic [3:0]            alloc_len,
  input  logic [AXI_ID_W-1:0]   rid,
  input  logic [AXI_DATA_W-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic                  cpl_valid,
  input  logic                  cpl_ready,
  output logic [TAG_W-1:0]      cpl_tag,
  output logic [1:0]            cpl_resp,
  output logic                  cpl_len_err,
  input  logic                  rb_req_valid,
  input  logic [TAG_W-1:0]      rb_tag,
  input  logic [3:0]            rb_beat,
  input  logic [RB_WORD_W-1:0]  rb_word,
  output logic                  rb_rsp_valid,
  output logic [APB_DATA_W-1:0] rb_rsp_data,
`ifdef APB2AXI_RBUF_PARITY_EN
  output logic                  rb_par_err,
  input  logic                  par_inject,
`endif
  input  logic                  free_valid,
  input  logic [TAG_W-1:0]      free_tag,
  output logic                  orphan_err
);

  localparam int NUM_TAGS = 2 ** TAG_W;
  localparam int BEAT_W   = 4;
  localparam int ADDR_W   = TAG_W + BEAT_W;

  rbuf_state_e      r_state    [NUM_TAGS];
  logic [3:0]       r_exp_len  [NUM_TAGS];
  logic [BEAT_W-1:0] r_beat_cnt [NUM_TAGS];
  logic [1:0]       r_worst    [NUM_TAGS];

  logic [COMPLETION_W-1:0] r_cpl_q;
  logic                    r_cpl_valid;
  logic                    r_orphan;
  logic                    r_rsp_valid;
  logic [RB_WORD_W-1:0]    r_rb_word;

  logic [TAG_W-1:0]      w_beat_tag;
  logic                  w_accept;
  logic                  w_filling;
  logic                  w_store;
  logic                  w_exp_last;
  logic                  w_burst_end;
  logic [1:0]            w_new_worst;
  completion_t           w_cpl_next;
  completion_t           w_cpl_out;
  logic [AXI_DATA_W-1:0] w_rd_data;
  logic [APB_DATA_W-1:0] w_word_sel;

  assign w_beat_tag  = rid[TAG_W-1:0];
  assign rready      = ~areset & (~r_cpl_valid | cpl_ready);
  assign w_accept    = rvalid & rready;
  assign w_filling   = (r_state[w_beat_tag] == RB_FILLING);
  assign w_store     = w_accept & w_filling;
  assign w_exp_last  = (r_beat_cnt[w_beat_tag] == r_exp_len[w_beat_tag]);
  // exp_len never exceeds MAX_BEATS-1, so a slot always closes before it can
  // overflow; any later beat for it lands on a DONE slot and is an orphan.
  assign w_burst_end = w_store & (rlast | w_exp_last);
  assign w_new_worst = resp_worst(r_worst[w_beat_tag], rresp);
  assign alloc_ready = (r_state[alloc_tag] == RB_FREE);

  always_comb begin
    w_cpl_next         = '0;
    w_cpl_next.tag     = w_beat_tag;
    w_cpl_next.resp    = w_new_worst;
    w_cpl_next.len_err = rlast ^ w_exp_last;
  end

  // Free, alloc and beat updates can only touch the same tag in disjoint states.
  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int t = 0; t < NUM_TAGS; t++) begin
        r_state[t]    <= RB_FREE;
        r_exp_len[t]  <= '0;
        r_beat_cnt[t] <= '0;
        r_worst[t]    <= AXI_RESP_OKAY;
      end
    end else begin
      if (free_valid && r_state[free_tag] == RB_DONE) r_state[free_tag] <= RB_FREE;
      if (alloc_valid && alloc_ready) begin
        r_state[alloc_tag]    <= RB_FILLING;
        r_exp_len[alloc_tag]  <= alloc_len;
        r_beat_cnt[alloc_tag] <= '0;
        r_worst[alloc_tag]    <= AXI_RESP_OKAY;
      end
      if (w_store) begin
        r_beat_cnt[w_beat_tag] <= r_beat_cnt[w_beat_tag] + 1'b1;
        r_worst[w_beat_tag]    <= w_new_worst;
        if (w_burst_end) r_state[w_beat_tag] <= RB_DONE;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_cpl_valid <= 1'b0;
      r_cpl_q     <= '0;
      r_orphan    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rb_word   <= '0;
    end else begin
      if (w_burst_end) begin
        r_cpl_valid <= 1'b1;
        r_cpl_q     <= w_cpl_next;
      end else if (cpl_ready) begin
        r_cpl_valid <= 1'b0;
      end
      if (w_accept && !w_filling) r_orphan <= 1'b1;
      r_rsp_valid <= rb_req_valid;
      r_rb_word   <= rb_word;
    end
  end

  assign w_cpl_out   = completion_t'(r_cpl_q);
  assign cpl_valid   = r_cpl_valid;
  assign cpl_tag     = w_cpl_out.tag;
  assign cpl_resp    = w_cpl_out.resp;
  assign cpl_len_err = w_cpl_out.len_err;
  assign orphan_err  = r_orphan;

  apb2axi_rbuf_ram #(
    .DATA_W (AXI_DATA_W),
    .DEPTH  (NUM_TAGS * MAX_BEATS),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk        (aclk),
    .wr_en      (w_store),
    .wr_addr    ({w_beat_tag, r_beat_cnt[w_beat_tag]}),
    .wr_data    (rdata),
`ifdef APB2AXI_RBUF_PARITY_EN
    .par_inject (par_inject),
    .rd_par     (w_rd_par),
`endif
    .rd_addr    ({rb_tag, rb_beat}),
    .rd_data    (w_rd_data)
  );

  assign w_word_sel   = w_rd_data[r_rb_word*APB_DATA_W +: APB_DATA_W];
  assign rb_rsp_valid = r_rsp_valid;
  assign rb_rsp_data  = r_rsp_valid ? w_word_sel : '0;

`ifdef APB2AXI_RBUF_PARITY_EN
  localparam int WORD_BYTES = APB_DATA_W / 8;

  logic [AXI_DATA_W/8-1:0] w_rd_par;
  logic [WORD_BYTES-1:0]   w_par_sel;
  logic [WORD_BYTES-1:0]   w_par_bad;

  assign w_par_sel = w_rd_par[r_rb_word*WORD_BYTES +: WORD_BYTES];
  for (genvar b = 0; b < WORD_BYTES; b++) begin : g_par_chk
    assign w_par_bad[b] = (^w_word_sel[8*b +: 8]) ^ w_par_sel[b];
  end
  assign rb_par_err = r_rsp_valid & (|w_par_bad);
`endif

endmodule
`default_nettype wire

// File: tb/tb_apb2axi_rdata_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb2axi_rdata_buffer
// Brief    : Table vectors, directed corner sequences and random bursts checked
//            against a queue/array reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_apb2axi_rdata_buffer;

  localparam int NT = 16;
  localparam int MB = 16;

  logic        aclk = 1'b0;
  logic        areset, alloc_valid, alloc_ready, rlast, rvalid, rready;
  logic [3:0]  alloc_tag, alloc_len, rid, free_tag, rb_tag, rb_beat, cpl_tag;
  logic [63:0] rdata;
  logic [1:0]  rresp, cpl_resp;
  logic        cpl_valid, cpl_ready, cpl_len_err, rb_req_valid, rb_rsp_valid;
  logic [0:0]  rb_word;
  logic [31:0] rb_rsp_data;
  logic        free_valid, orphan_err;
`ifdef APB2AXI_RBUF_PARITY_EN
  logic        rb_par_err, par_inject;
`endif

  always #5 aclk = ~aclk;

  apb2axi_rdata_buffer dut (
    .aclk(aclk), .areset(areset),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_tag(alloc_tag), .alloc_len(alloc_len),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .cpl_valid(cpl_valid), .cpl_ready(cpl_ready),
    .cpl_tag(cpl_tag), .cpl_resp(cpl_resp), .cpl_len_err(cpl_len_err),
    .rb_req_valid(rb_req_valid), .rb_tag(rb_tag), .rb_beat(rb_beat),
    .rb_word(rb_word), .rb_rsp_valid(rb_rsp_valid), .rb_rsp_data(rb_rsp_data),
`ifdef APB2AXI_RBUF_PARITY_EN
    .rb_par_err(rb_par_err), .par_inject(par_inject),
`endif
    .free_valid(free_valid), .free_tag(free_tag), .orphan_err(orphan_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int         tag;
    logic [1:0] resp;
    bit         len_err;
  } cpl_exp_t;

  int          m_state [NT];   // 0 free, 1 filling, 2 done
  int          m_need  [NT];
  int          m_got   [NT];
  logic [1:0]  m_worst [NT];
  logic [63:0] m_mem   [NT*MB];
  bit          m_wr    [NT*MB];
  bit          m_orphan;
  cpl_exp_t    m_cpl_q [$];

  function automatic void model_reset();
    for (int t = 0; t < NT; t++) m_state[t] = 0;
    m_orphan = 0;
    m_cpl_q.delete();
  endfunction

  function automatic void model_alloc(input int tag, input int len);
    m_state[tag] = 1; m_need[tag] = len + 1; m_got[tag] = 0; m_worst[tag] = 2'd0;
  endfunction

  function automatic void model_beat(input int tag, input logic [63:0] d,
                                     input logic [1:0] r, input bit last);
    cpl_exp_t e;
    if (m_state[tag] != 1) begin
      m_orphan = 1;
      return;
    end
    m_mem[tag*MB + m_got[tag]] = d;
    m_wr[tag*MB + m_got[tag]]  = 1;
    m_got[tag]++;
    if (r > m_worst[tag]) m_worst[tag] = r;
    if (last || m_got[tag] == m_need[tag]) begin
      m_state[tag] = 2;
      e.tag = tag; e.resp = m_worst[tag]; e.len_err = (last != (m_got[tag] == m_need[tag]));
      m_cpl_q.push_back(e);
    end
  endfunction

  function automatic logic [31:0] model_word(input int tag, input int beat, input int word);
    logic [63:0] w;
    w = m_mem[tag*MB + beat];
    return (word != 0) ? w[63:32] : w[31:0];
  endfunction

  // Completion scoreboard: a handshake seen here completes on the next edge.
  always @(negedge aclk) begin
    cpl_exp_t e;
    if (!areset && cpl_valid && cpl_ready) begin
      if (m_cpl_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL cpl_unexpected: got tag %0d expected none", cpl_tag);
      end else begin
        e = m_cpl_q.pop_front();
        check("sb_cpl_tag", 64'(cpl_tag), 64'(e.tag));
        check("sb_cpl_resp", 64'(cpl_resp), 64'(e.resp));
        check("sb_cpl_len_err", 64'(cpl_len_err), 64'(e.len_err));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic cyc();
    @(posedge aclk); #1;
  endtask

  task automatic do_alloc(input int tag, input int len);
    int n = 0;
    alloc_valid = 1'b1; alloc_tag = 4'(tag); alloc_len = 4'(len);
    #1;
    while (!alloc_ready && n < 20) begin cyc(); n++; end
    if (!alloc_ready) fail_now("alloc_wait");
    else model_alloc(tag, len);
    cyc();
    alloc_valid = 1'b0;
  endtask

  task automatic send_beat(input int tag, input logic [63:0] d, input logic [1:0] r,
                           input bit last, input bit rand_ready);
    int  n = 0;
    bit  ok = 0;
    rvalid = 1'b1; rid = 4'(tag); rdata = d; rresp = r; rlast = last;
    while (!ok && n < 50) begin
      if (rand_ready) cpl_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (rready) ok = 1;
      else begin cyc(); n++; end
    end
    if (!ok) fail_now("beat_wait");
    else begin
      model_beat(tag, d, r, last);
      cyc();
    end
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  task automatic do_free(input int tag);
    free_valid = 1'b1; free_tag = 4'(tag);
    cyc();
    free_valid = 1'b0;
    if (m_state[tag] == 2) m_state[tag] = 0;
  endtask

  task automatic readback(input int tag, input int beat, input int word);
    rb_req_valid = 1'b1; rb_tag = 4'(tag); rb_beat = 4'(beat); rb_word = 1'(word);
    cyc();
    rb_req_valid = 1'b0;
    check("rb_rsp_valid", 64'(rb_rsp_valid), 64'd1);
    check("rb_rsp_data", 64'(rb_rsp_data), 64'(model_word(tag, beat, word)));
`ifdef APB2AXI_RBUF_PARITY_EN
    check("rb_par_err", 64'(rb_par_err), 64'd0);
`endif
  endtask

  task automatic drain();
    cpl_ready = 1'b1;
    repeat (3) cyc();
    check("drain_queue_empty", 64'(m_cpl_q.size()), 64'd0);
    check("drain_cpl_valid", 64'(cpl_valid), 64'd0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int         tag;
    int         len;
    int         nbeats;
    int         last_at;    // -1: no RLAST at all
    int         resp_at;
    logic [1:0] resp_val;
    logic [1:0] exp_resp;
    bit         exp_len_err;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [63:0] d, old;
    bit          seen;

    vecs[0] = '{tag: 3,  len: 3,  nbeats: 4,  last_at: 3,  resp_at: 0, resp_val: 2'd0, exp_resp: 2'd0, exp_len_err: 1'b0};
    vecs[1] = '{tag: 5,  len: 1,  nbeats: 2,  last_at: 1,  resp_at: 1, resp_val: 2'd2, exp_resp: 2'd2, exp_len_err: 1'b0};
    vecs[2] = '{tag: 1,  len: 3,  nbeats: 3,  last_at: 1,  resp_at: 0, resp_val: 2'd0, exp_resp: 2'd0, exp_len_err: 1'b1};
    vecs[3] = '{tag: 8,  len: 2,  nbeats: 3,  last_at: -1, resp_at: 1, resp_val: 2'd3, exp_resp: 2'd3, exp_len_err: 1'b1};
    vecs[4] = '{tag: 9,  len: 0,  nbeats: 1,  last_at: 0,  resp_at: 0, resp_val: 2'd1, exp_resp: 2'd1, exp_len_err: 1'b0};
    vecs[5] = '{tag: 10, len: 15, nbeats: 16, last_at: 15, resp_at: 7, resp_val: 2'd2, exp_resp: 2'd2, exp_len_err: 1'b0};
    vecs[6] = '{tag: 11, len: 15, nbeats: 17, last_at: -1, resp_at: 3, resp_val: 2'd1, exp_resp: 2'd1, exp_len_err: 1'b1};

    areset = 1'b1; alloc_valid = 0; alloc_tag = 0; alloc_len = 0;
    rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0; cpl_ready = 0;
    rb_req_valid = 0; rb_tag = 0; rb_beat = 0; rb_word = 0; free_valid = 0; free_tag = 0;
`ifdef APB2AXI_RBUF_PARITY_EN
    par_inject = 1'b0;
`endif
    for (int i = 0; i < NT*MB; i++) m_wr[i] = 0;
    model_reset();

    repeat (3) cyc();
    check("rst_rready", 64'(rready), 64'd0);
    check("rst_cpl_valid", 64'(cpl_valid), 64'd0);
    check("rst_rb_rsp_valid", 64'(rb_rsp_valid), 64'd0);
    check("rst_orphan_err", 64'(orphan_err), 64'd0);
    check("rst_cpl_payload", 64'({cpl_tag, cpl_resp, cpl_len_err}), 64'd0);
    check("rst_rb_rsp_data", 64'(rb_rsp_data), 64'd0);
    areset = 1'b0;
    #1;
    check("post_rst_rready", 64'(rready), 64'd1);
    cyc();

    // ---- table-driven bursts ----
    foreach (vecs[i]) begin
      cpl_ready = 1'b0;
      seen = 0;
      do_alloc(vecs[i].tag, vecs[i].len);
      for (int b = 0; b < vecs[i].nbeats; b++) begin
        d = {8'(vecs[i].tag), 8'(b), 16'hBEEF, 32'h11 * (b + 1)};
        send_beat(vecs[i].tag, d, (b == vecs[i].resp_at) ? vecs[i].resp_val : 2'd0,
                  b == vecs[i].last_at, 0);
        if (!seen && cpl_valid) begin
          seen = 1;
          check($sformatf("vec%0d_cpl_tag", i), 64'(cpl_tag), 64'(vecs[i].tag));
          check($sformatf("vec%0d_cpl_resp", i), 64'(cpl_resp), 64'(vecs[i].exp_resp));
          check($sformatf("vec%0d_cpl_len_err", i), 64'(cpl_len_err), 64'(vecs[i].exp_len_err));
          cpl_ready = 1'b1;
        end
      end
      check($sformatf("vec%0d_cpl_seen", i), 64'(seen), 64'd1);
      drain();
      check($sformatf("vec%0d_orphan_err", i), 64'(orphan_err), 64'(m_orphan));
      readback(vecs[i].tag, 0, 0);
      readback(vecs[i].tag, m_got[vecs[i].tag] - 1, 1);
      if (i == 0) begin
        readback(3, 2, 1);
        check("vec0_beat2_word1_const", 64'(rb_rsp_data), 64'h0302BEEF);
      end
      do_free(vecs[i].tag);
    end

    // ---- completion backpressure: tags 2 and 4 back to back ----
    cpl_ready = 1'b0;
    do_alloc(2, 0);
    do_alloc(4, 0);
    send_beat(2, 64'hAAAA_0002_0000_0002, 2'd0, 1, 0);
    check("bp_cpl_valid", 64'(cpl_valid), 64'd1);
    check("bp_rready_low", 64'(rready), 64'd0);
    rvalid = 1'b1; rid = 4'd4; rdata = 64'hAAAA_0004_0000_0004; rresp = 2'd1; rlast = 1'b1;
    repeat (2) begin
      cyc();
      check("bp_hold_rready", 64'(rready), 64'd0);
      check("bp_hold_tag", 64'(cpl_tag), 64'd2);
    end
    cpl_ready = 1'b1;
    #1;
    check("bp_release_rready", 64'(rready), 64'd1);
    model_beat(4, rdata, rresp, 1);
    cyc();
    rvalid = 1'b0; rlast = 1'b0;
    check("bp_second_valid", 64'(cpl_valid), 64'd1);
    check("bp_second_tag", 64'(cpl_tag), 64'd4);
    drain();
    do_free(2);
    do_free(4);

    // ---- alloc blocked on DONE, free/alloc same cycle, read-before-write ----
    do_alloc(7, 0);
    send_beat(7, 64'h7777_0000_1234_5678, 2'd0, 1, 0);
    drain();
    alloc_valid = 1'b1; alloc_tag = 4'd7; alloc_len = 4'd0;
    #1;
    check("done_alloc_ready", 64'(alloc_ready), 64'd0);
    free_valid = 1'b1; free_tag = 4'd7;
    #1;
    check("free_same_cycle_alloc_ready", 64'(alloc_ready), 64'd0);
    cyc();
    free_valid = 1'b0;
    m_state[7] = 0;
    #1;
    check("after_free_alloc_ready", 64'(alloc_ready), 64'd1);
    cyc();
    model_alloc(7, 0);
    alloc_valid = 1'b0;
    old = m_mem[7*MB];
    rvalid = 1'b1; rid = 4'd7; rdata = 64'h7777_1111_9ABC_DEF0; rresp = 2'd0; rlast = 1'b1;
    rb_req_valid = 1'b1; rb_tag = 4'd7; rb_beat = 4'd0; rb_word = 1'b0;
    #1;
    check("rbw_rready", 64'(rready), 64'd1);
    model_beat(7, rdata, 2'd0, 1);
    cyc();
    rvalid = 1'b0; rlast = 1'b0; rb_req_valid = 1'b0;
    check("rbw_old_data", 64'(rb_rsp_data), 64'(old[31:0]));
    readback(7, 0, 0);
    drain();
    do_free(7);

    // ---- random bursts against the model ----
    for (int it = 0; it < 40; it++) begin
      int tag, len, mode, nb, last_at, tries;
      tag  = $urandom_range(0, NT - 1);
      len  = $urandom_range(0, 15);
      mode = $urandom_range(0, 3);
      if (mode == 2) begin last_at = $urandom_range(0, len); nb = last_at + 1; end
      else if (mode == 3) begin last_at = -1; nb = len + 2; end
      else begin last_at = len; nb = len + 1; end
      do_alloc(tag, len);
      for (int b = 0; b < nb; b++)
        send_beat(tag, {$urandom, $urandom}, 2'($urandom_range(0, 3)), b == last_at, 1);
      if ($urandom_range(0, 4) == 0)
        send_beat((tag + 1) % NT, {$urandom, $urandom}, 2'd0, 1, 1);
      drain();
      check("rand_orphan_err", 64'(orphan_err), 64'(m_orphan));
      tries = 0;
      for (int k = 0; k < 3; k++) begin
        int t2, b2;
        t2 = $urandom_range(0, NT - 1);
        b2 = $urandom_range(0, MB - 1);
        if (m_wr[t2*MB + b2]) readback(t2, b2, $urandom_range(0, 1));
        else tries++;
      end
      do_free(tag);
      if (tries == 3) do_free(tag);
    end

    // ---- reset in the middle of a burst on tag 6 ----
    cpl_ready = 1'b0;
    do_alloc(6, 3);
    send_beat(6, 64'h6666_0000_0000_0000, 2'd0, 0, 0);
    send_beat(6, 64'h6666_0000_0000_0001, 2'd0, 0, 0);
    areset = 1'b1;
    #1;
    check("midrst_rready", 64'(rready), 64'd0);
    cyc();
    cyc();
    areset = 1'b0;
    model_reset();
    check("midrst_cpl_valid", 64'(cpl_valid), 64'd0);
    check("midrst_orphan_err", 64'(orphan_err), 64'd0);
    check("midrst_rb_rsp_valid", 64'(rb_rsp_valid), 64'd0);
    for (int t = 0; t < NT; t++) begin
      alloc_tag = 4'(t);
      #1;
      check($sformatf("midrst_alloc_ready_t%0d", t), 64'(alloc_ready), 64'd1);
    end
    cpl_ready = 1'b1;
    send_beat(6, 64'h6666_0000_0000_0002, 2'd0, 1, 0);
    check("midrst_orphan_after", 64'(orphan_err), 64'd1);
    check("midrst_no_cpl", 64'(cpl_valid), 64'd0);
    check("final_queue_empty", 64'(m_cpl_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
